// File: rtl/native_delay_sweeper.sv
// native_delay_sweeper: native-port initiator that steps IDELAY taps with VTC held off,
// verifies each tap by readback, and reports the high-sample count per tap.
module native_delay_sweeper #(
   parameter int NATIVE_ADDR_WDITH = 2,
   parameter int NATIVE_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int SETTLE_CYCLES = 16,
   parameter int WINDOW_CYCLES = 256
) (
   input  logic                         NATIVE_CLK,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [8:0]                   tap_first,
   input  logic [8:0]                   tap_last,
   input  logic [8:0]                   tap_step,
   input  logic                         sample_in,
   output logic                         busy,
   output logic                         done,
   output logic [1:0]                   error,
   output logic                         res_valid,
   output logic [8:0]                   res_tap,
   output logic [8:0]                   res_ones,
   output logic                         NATIVE_EN,
   output logic                         NATIVE_WR,
   output logic [NATIVE_ADDR_WDITH-1:0] NATIVE_ADDR,
   output logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_IN,
   input  logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_OUT,
   input  logic                         NATIVE_READY
);
   localparam int MX_SW = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
   localparam int MX = (TIMEOUT_CYCLES > MX_SW) ? TIMEOUT_CYCLES : MX_SW;
   localparam int CW = $clog2(MX);
   typedef enum logic [3:0] {IDLE, VTC_OFF, SET, READ, SETTLE, SAMPLE, REPORT, VTC_ON, FIN, WAIT} state_t;
   state_t state_q, state_d, ret_q, ret_d, iss_ret;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [8:0] cur_q, cur_d, last_q, last_d, step_q, step_d, ones_q, ones_d;
   logic [8:0] res_tap_q, res_tap_d, res_ones_q, res_ones_d;
   logic busy_q, busy_d, done_q, done_d, res_valid_q, res_valid_d;
   logic [1:0] error_q, error_d;
   logic en_q, en_d, wr_q, wr_d, iss, iss_wr;
   logic [NATIVE_ADDR_WDITH-1:0] addr_q, addr_d, iss_addr;
   logic [NATIVE_DATA_WIDTH-1:0] data_q, data_d, iss_data;
   logic [9:0] nxt;
   logic unused_ok;
   assign unused_ok = &{1'b0, NATIVE_DATA_OUT[NATIVE_DATA_WIDTH-1:9]};
   assign nxt = {1'b0, cur_q} + {1'b0, step_q};
   always_comb begin
      state_d = state_q;
      ret_d = ret_q;
      cnt_d = cnt_q;
      cur_d = cur_q;
      last_d = last_q;
      step_d = step_q;
      ones_d = ones_q;
      res_tap_d = res_tap_q;
      res_ones_d = res_ones_q;
      busy_d = busy_q;
      done_d = 1'b0;
      res_valid_d = 1'b0;
      error_d = error_q;
      en_d = 1'b0;
      wr_d = wr_q;
      addr_d = addr_q;
      data_d = data_q;
      iss = 1'b0;
      iss_wr = 1'b1;
      iss_addr = '0;
      iss_data = data_q;
      iss_ret = IDLE;
      case (state_q)
         IDLE: if (start) begin
            if (tap_first > tap_last) begin
               error_d = 2'b11;
               done_d = 1'b1;
            end else begin
               error_d = 2'b00;
               busy_d = 1'b1;
               cur_d = tap_first;
               last_d = tap_last;
               step_d = (tap_step == 9'd0) ? 9'd1 : tap_step;
               state_d = VTC_OFF;
            end
         end
         VTC_OFF: begin
            iss = 1'b1;
            iss_addr = NATIVE_ADDR_WDITH'(1);
            iss_data = '0;
            iss_ret = SET;
         end
         SET: begin
            iss = 1'b1;
            iss_data = NATIVE_DATA_WIDTH'(cur_q);
            iss_ret = READ;
         end
         READ: begin
            iss = 1'b1;
            iss_wr = 1'b0;
            iss_ret = SETTLE;
         end
         // EN cycle has cnt 0; READY only counts from the 3rd cycle after it
         WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q >= CW'(3) && NATIVE_READY) begin
               if (!wr_q && NATIVE_DATA_OUT[8:0] != cur_q) error_d = 2'b10;
               state_d = ret_q;
               cnt_d = '0;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               error_d = 2'b01;
               state_d = (ret_q == FIN) ? FIN : VTC_ON;
               cnt_d = '0;
            end
         end
         SETTLE: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
               cnt_d = '0;
               ones_d = '0;
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            cnt_d = cnt_q + CW'(1);
            if (sample_in && ones_q != 9'h1FF) ones_d = ones_q + 9'd1;
            if (cnt_q == CW'(WINDOW_CYCLES - 1)) begin
               cnt_d = '0;
               state_d = REPORT;
            end
         end
         REPORT: begin
            res_valid_d = 1'b1;
            res_tap_d = cur_q;
            res_ones_d = ones_q;
            if (nxt > {1'b0, last_q}) state_d = VTC_ON;
            else begin
               cur_d = nxt[8:0];
               state_d = SET;
            end
         end
         VTC_ON: begin
            iss = 1'b1;
            iss_addr = NATIVE_ADDR_WDITH'(1);
            iss_data = NATIVE_DATA_WIDTH'(1);
            iss_ret = FIN;
         end
         FIN: begin
            done_d = 1'b1;
            busy_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (iss) begin
         en_d = 1'b1;
         wr_d = iss_wr;
         addr_d = iss_addr;
         data_d = iss_data;
         ret_d = iss_ret;
         cnt_d = '0;
         state_d = WAIT;
      end
   end
   always_ff @(posedge NATIVE_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ret_q <= IDLE;
         cnt_q <= '0;
         cur_q <= '0;
         last_q <= '0;
         step_q <= '0;
         ones_q <= '0;
         res_tap_q <= '0;
         res_ones_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         res_valid_q <= 1'b0;
         error_q <= 2'b00;
         en_q <= 1'b0;
         wr_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         state_q <= state_d;
         ret_q <= ret_d;
         cnt_q <= cnt_d;
         cur_q <= cur_d;
         last_q <= last_d;
         step_q <= step_d;
         ones_q <= ones_d;
         res_tap_q <= res_tap_d;
         res_ones_q <= res_ones_d;
         busy_q <= busy_d;
         done_q <= done_d;
         res_valid_q <= res_valid_d;
         error_q <= error_d;
         en_q <= en_d;
         wr_q <= wr_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign error = error_q;
   assign res_valid = res_valid_q;
   assign res_tap = res_tap_q;
   assign res_ones = res_ones_q;
   assign NATIVE_EN = en_q;
   assign NATIVE_WR = wr_q;
   assign NATIVE_ADDR = addr_q;
   assign NATIVE_DATA_IN = data_q;
endmodule
